// File: rtl/multi_divi_metric_eval_if.sv
// Index-beat channel from the candidate index generator to the metric evaluator.
// The generator side is the master; the evaluator answers with idx_ready.
interface multi_divi_metric_eval_if #(
   parameter int J = 14,
   parameter int A = 2
);
   localparam int AWIDTH  = $clog2(A) + 1;
   localparam int J_WIDTH = $clog2(J) + 1;

   logic [AWIDTH-1:0]  mutli_col_idx1;
   logic [AWIDTH-1:0]  mutli_col_idx2;
   logic [AWIDTH-1:0]  divi_col_idx1;
   logic [AWIDTH-1:0]  divi_col_idx2;
   logic [J_WIDTH-1:0] multi_row_idx;
   logic [J_WIDTH-1:0] multi_row_idx2;
   logic [J_WIDTH-1:0] divi_row_idx;
   logic [J_WIDTH-1:0] divi_row_idx2;
   logic [1:0]         state_in;
   logic               index_in_tvalid;
   logic               idx_ready;

   modport master (
      output mutli_col_idx1, mutli_col_idx2, divi_col_idx1, divi_col_idx2,
      output multi_row_idx, multi_row_idx2, divi_row_idx, divi_row_idx2,
      output state_in, index_in_tvalid,
      input  idx_ready
   );

   modport slave (
      input  mutli_col_idx1, mutli_col_idx2, divi_col_idx1, divi_col_idx2,
      input  multi_row_idx, multi_row_idx2, divi_row_idx, divi_row_idx2,
      input  state_in, index_in_tvalid,
      output idx_ready
   );
endinterface

// File: rtl/multi_divi_metric_eval.sv
// Log-domain metric evaluator: accumulates the base metric of x_initial, then scores
// every multiply/divide index beat against it and keeps the strictly-best candidate.
module multi_divi_metric_eval #(
   parameter  int J       = 14,
   parameter  int A       = 2,
   parameter  int W       = 16,
   localparam int AWIDTH  = $clog2(A) + 1,
   localparam int J_WIDTH = $clog2(J) + 1,
   localparam int MW      = W + J_WIDTH + 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       tbl_wr_en,
   input  logic [J_WIDTH-1:0]         tbl_wr_row,
   input  logic [AWIDTH-1:0]          tbl_wr_col,
   input  logic signed [W-1:0]        tbl_wr_data,
   input  logic [J*AWIDTH-1:0]        x_initial,
   input  logic                       x_initial_tvalid,
   multi_divi_metric_eval_if.slave    idx_if,
   output logic signed [MW-1:0]       base_metric,
   output logic signed [MW-1:0]       best_metric,
   output logic [J_WIDTH-1:0]         best_row_idx,
   output logic [J_WIDTH-1:0]         best_row_idx2,
   output logic [AWIDTH-1:0]          best_col_idx1,
   output logic [AWIDTH-1:0]          best_col_idx2,
   output logic                       best_is_pair,
   output logic [15:0]                cand_count,
   output logic                       result_tvalid,
   output logic                       err
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_BASE  = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_FLUSH = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [1:0] GEN_SINGLE = 2'b01;
   localparam logic [1:0] GEN_PAIR   = 2'b10;
   localparam logic [1:0] GEN_DONE   = 2'b11;

   localparam int RI_W = (J > 1) ? $clog2(J) : 1;
   localparam int CI_W = (A > 1) ? $clog2(A) : 1;
   localparam logic [J_WIDTH-1:0] J_ROW  = J_WIDTH'(J);
   localparam logic [J_WIDTH-1:0] J_LAST = J_WIDTH'(J - 1);
   localparam logic [AWIDTH-1:0]  A_COL  = AWIDTH'(A);

   function automatic logic in_range(input logic [J_WIDTH-1:0] row,
                                     input logic [AWIDTH-1:0]  col);
      return (row < J_ROW) && (col < A_COL);
   endfunction

   function automatic logic signed [MW-1:0] sext(input logic signed [W-1:0] v);
      return MW'(v);
   endfunction

   logic [2:0]                r_state;
   logic [J_WIDTH-1:0]        r_j;
   logic                      r_flush;
   logic signed [MW-1:0]      r_acc;
   logic signed [MW-1:0]      r_base_metric;
   logic signed [MW-1:0]      r_best_metric;
   logic [J_WIDTH-1:0]        r_best_row;
   logic [J_WIDTH-1:0]        r_best_row2;
   logic [AWIDTH-1:0]         r_best_col1;
   logic [AWIDTH-1:0]         r_best_col2;
   logic                      r_best_pair;
   logic [15:0]               r_cand_count;
   logic                      r_err;
   logic signed [W-1:0]       r_tbl [J][A];
   logic [AWIDTH-1:0]         r_x [J];

   logic                      r_vld_p1;
   logic                      r_pair_p1;
   logic signed [W-1:0]       r_mul1_p1, r_div1_p1, r_mul2_p1, r_div2_p1;
   logic [J_WIDTH-1:0]        r_mr_p1, r_mr2_p1;
   logic [AWIDTH-1:0]         r_mc1_p1, r_mc2_p1;

   logic                      w_start;
   logic                      w_p1_ok, w_p2_ok, w_beat_ok, w_beat_acc, w_err_set;
   logic [AWIDTH-1:0]         w_xj;
   logic signed [W-1:0]       w_base_ent;
   logic signed [MW-1:0]      w_acc_next;
   logic signed [W-1:0]       w_mul1, w_div1, w_mul2, w_div2;
   logic signed [MW-1:0]      w_pair_p2;
   logic signed [MW-1:0]      w_cand_p2;

   assign w_start = (r_state == S_IDLE) && x_initial_tvalid;

   // Table: async-cleared, writable only while idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < J; i++)
            for (int k = 0; k < A; k++)
               r_tbl[i][k] <= '0;
      end else if ((r_state == S_IDLE) && tbl_wr_en && in_range(tbl_wr_row, tbl_wr_col)) begin
         r_tbl[tbl_wr_row[RI_W-1:0]][tbl_wr_col[CI_W-1:0]] <= tbl_wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (w_start)
         for (int i = 0; i < J; i++)
            r_x[i] <= x_initial[i*AWIDTH +: AWIDTH];
   end

   assign w_xj       = r_x[r_j[RI_W-1:0]];
   assign w_base_ent = in_range(r_j, w_xj) ? r_tbl[r_j[RI_W-1:0]][w_xj[CI_W-1:0]] : '0;
   assign w_acc_next = r_acc + sext(w_base_ent);

   assign w_mul1 = in_range(idx_if.multi_row_idx, idx_if.mutli_col_idx1)
                 ? r_tbl[idx_if.multi_row_idx[RI_W-1:0]][idx_if.mutli_col_idx1[CI_W-1:0]] : '0;
   assign w_div1 = in_range(idx_if.divi_row_idx, idx_if.divi_col_idx1)
                 ? r_tbl[idx_if.divi_row_idx[RI_W-1:0]][idx_if.divi_col_idx1[CI_W-1:0]] : '0;
   assign w_mul2 = in_range(idx_if.multi_row_idx2, idx_if.mutli_col_idx2)
                 ? r_tbl[idx_if.multi_row_idx2[RI_W-1:0]][idx_if.mutli_col_idx2[CI_W-1:0]] : '0;
   assign w_div2 = in_range(idx_if.divi_row_idx2, idx_if.divi_col_idx2)
                 ? r_tbl[idx_if.divi_row_idx2[RI_W-1:0]][idx_if.divi_col_idx2[CI_W-1:0]] : '0;

   // Single beats only check the indices they use; pair beats check all four.
   assign w_p1_ok    = in_range(idx_if.multi_row_idx, idx_if.mutli_col_idx1) &&
                       in_range(idx_if.divi_row_idx, idx_if.divi_col_idx1);
   assign w_p2_ok    = in_range(idx_if.multi_row_idx2, idx_if.mutli_col_idx2) &&
                       in_range(idx_if.divi_row_idx2, idx_if.divi_col_idx2);
   assign w_beat_ok  = ((idx_if.state_in == GEN_SINGLE) && w_p1_ok) ||
                       ((idx_if.state_in == GEN_PAIR) && w_p1_ok && w_p2_ok);
   assign w_beat_acc = (r_state == S_RUN) && idx_if.index_in_tvalid && w_beat_ok;
   assign w_err_set  = (tbl_wr_en && (r_state != S_IDLE)) ||
                       (x_initial_tvalid && (r_state != S_IDLE)) ||
                       (idx_if.index_in_tvalid && !w_beat_acc);

   // Stage 1: capture table reads and beat context
   always_ff @(posedge clk) begin
      if (w_beat_acc) begin
         r_pair_p1 <= idx_if.state_in[1];
         r_mul1_p1 <= w_mul1;
         r_div1_p1 <= w_div1;
         r_mul2_p1 <= w_mul2;
         r_div2_p1 <= w_div2;
         r_mr_p1   <= idx_if.multi_row_idx;
         r_mr2_p1  <= idx_if.multi_row_idx2;
         r_mc1_p1  <= idx_if.mutli_col_idx1;
         r_mc2_p1  <= idx_if.mutli_col_idx2;
      end
   end

   // Stage 2: candidate metric from the stage-1 registers
   always_comb begin
      w_pair_p2 = '0;
      if (r_pair_p1)
         w_pair_p2 = sext(r_mul2_p1) - sext(r_div2_p1);
   end

   assign w_cand_p2 = r_base_metric + sext(r_mul1_p1) - sext(r_div1_p1) + w_pair_p2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_j           <= '0;
         r_flush       <= 1'b0;
         r_acc         <= '0;
         r_base_metric <= '0;
         r_best_metric <= '0;
         r_best_row    <= J_ROW;
         r_best_row2   <= J_ROW;
         r_best_col1   <= '0;
         r_best_col2   <= '0;
         r_best_pair   <= 1'b0;
         r_cand_count  <= '0;
         r_err         <= 1'b0;
         r_vld_p1      <= 1'b0;
      end else begin
         r_err    <= (w_start ? 1'b0 : r_err) | w_err_set;
         r_vld_p1 <= w_beat_acc;
         case (r_state)
            S_IDLE: begin
               if (x_initial_tvalid) begin
                  r_acc        <= '0;
                  r_j          <= '0;
                  r_cand_count <= '0;
                  r_state      <= S_BASE;
               end
            end
            S_BASE: begin
               r_acc <= w_acc_next;
               if (r_j == J_LAST) begin
                  r_base_metric <= w_acc_next;
                  r_best_metric <= w_acc_next;
                  r_best_row    <= J_ROW;
                  r_best_row2   <= J_ROW;
                  r_best_col1   <= '0;
                  r_best_col2   <= '0;
                  r_best_pair   <= 1'b0;
                  r_state       <= S_RUN;
               end else begin
                  r_j <= r_j + 1'b1;
               end
            end
            S_RUN: begin
               if (idx_if.state_in == GEN_DONE) begin
                  r_flush <= 1'b0;
                  r_state <= S_FLUSH;
               end
            end
            S_FLUSH: begin
               r_flush <= 1'b1;
               if (r_flush)
                  r_state <= S_DONE;
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase

         // Strict compare keeps the first-found candidate on ties
         if (r_vld_p1) begin
            if (r_cand_count != 16'hFFFF)
               r_cand_count <= r_cand_count + 16'd1;
            if (w_cand_p2 > r_best_metric) begin
               r_best_metric <= w_cand_p2;
               r_best_row    <= r_mr_p1;
               r_best_row2   <= r_pair_p1 ? r_mr2_p1 : J_ROW;
               r_best_col1   <= r_mc1_p1;
               r_best_col2   <= r_pair_p1 ? r_mc2_p1 : '0;
               r_best_pair   <= r_pair_p1;
            end
         end
      end
   end

   assign idx_if.idx_ready = (r_state == S_RUN);
   assign result_tvalid    = (r_state == S_DONE);
   assign base_metric      = r_base_metric;
   assign best_metric      = r_best_metric;
   assign best_row_idx     = r_best_row;
   assign best_row_idx2    = r_best_row2;
   assign best_col_idx1    = r_best_col1;
   assign best_col_idx2    = r_best_col2;
   assign best_is_pair     = r_best_pair;
   assign cand_count       = r_cand_count;
   assign err              = r_err;
endmodule

// File: tb/tb_multi_divi_metric_eval.sv
// Directed bench for multi_divi_metric_eval: a spec-level model pushes the expected
// run result to a queue, which is popped and checked when result_tvalid pulses.
module tb_multi_divi_metric_eval;
   localparam int J  = 14;
   localparam int A  = 2;
   localparam int W  = 16;
   localparam int AW = 2;
   localparam int JW = 5;
   localparam int MW = 23;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic                 tbl_wr_en = 1'b0;
   logic [JW-1:0]        tbl_wr_row = '0;
   logic [AW-1:0]        tbl_wr_col = '0;
   logic signed [W-1:0]  tbl_wr_data = '0;
   logic [J*AW-1:0]      x_initial = '0;
   logic                 x_initial_tvalid = 1'b0;
   logic signed [MW-1:0] base_metric, best_metric;
   logic [JW-1:0]        best_row_idx, best_row_idx2;
   logic [AW-1:0]        best_col_idx1, best_col_idx2;
   logic                 best_is_pair;
   logic [15:0]          cand_count;
   logic                 result_tvalid, err;

   multi_divi_metric_eval_if #(.J(J), .A(A)) ifc ();

   multi_divi_metric_eval #(.J(J), .A(A), .W(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .tbl_wr_en(tbl_wr_en), .tbl_wr_row(tbl_wr_row), .tbl_wr_col(tbl_wr_col),
      .tbl_wr_data(tbl_wr_data),
      .x_initial(x_initial), .x_initial_tvalid(x_initial_tvalid),
      .idx_if(ifc),
      .base_metric(base_metric), .best_metric(best_metric),
      .best_row_idx(best_row_idx), .best_row_idx2(best_row_idx2),
      .best_col_idx1(best_col_idx1), .best_col_idx2(best_col_idx2),
      .best_is_pair(best_is_pair), .cand_count(cand_count),
      .result_tvalid(result_tvalid), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int base; int best; int row; int row2; int col1; int col2; int cnt; bit pair; bit err;
   } exp_t;
   exp_t sb[$];

   int    n_assert = 0;
   int    n_fail   = 0;
   string cur_test = "reset";

   int m_tbl [J][A];
   int m_base, m_best, m_row, m_row2, m_col1, m_col2, m_cnt;
   bit m_pair, m_err, m_run;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s/%s: observed %0d expected %0d", cur_test, tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic bit rng(input int r, input int c);
      return (r >= 0) && (r < J) && (c >= 0) && (c < A);
   endfunction

   task automatic wr(input int r, input int c, input int d);
      tbl_wr_en   = 1'b1;
      tbl_wr_row  = JW'(r);
      tbl_wr_col  = AW'(c);
      tbl_wr_data = W'(d);
      if (rng(r, c)) m_tbl[r][c] = d;
      cyc();
      tbl_wr_en = 1'b0;
   endtask

   task automatic idle();
      ifc.index_in_tvalid = 1'b0;
      ifc.state_in        = 2'b00;
   endtask

   task automatic start(input logic [J-1:0] xbits, input bit base_beat);
      m_run  = 1'b0;
      m_err  = 1'b0;
      m_base = 0;
      for (int j = 0; j < J; j++) begin
         x_initial[j*AW +: AW] = AW'(xbits[j]);
         m_base += m_tbl[j][xbits[j]];
      end
      m_best = m_base; m_row = J; m_row2 = J; m_col1 = 0; m_col2 = 0; m_pair = 0; m_cnt = 0;
      x_initial_tvalid = 1'b1;
      cyc();
      x_initial_tvalid = 1'b0;
      for (int i = 0; i < J - 1; i++) begin
         if (i == 0 && base_beat) begin
            ifc.state_in        = 2'b01;
            ifc.index_in_tvalid = 1'b1;
            m_err               = 1'b1;
         end
         cyc();
         idle();
      end
      chk("idx_ready_before", ifc.idx_ready, 0);
      cyc();
      chk("idx_ready_after", ifc.idx_ready, 1);
      chk("base_metric_start", base_metric, m_base);
      m_run = 1'b1;
   endtask

   task automatic beat(input logic [1:0] st, input int mr, input int mc1, input int dr, input int dc1,
                       input int mr2 = 0, input int mc2 = 0, input int dr2 = 0, input int dc2 = 0);
      bit ok;
      int cand;
      ifc.state_in        = st;
      ifc.multi_row_idx   = JW'(mr);
      ifc.mutli_col_idx1  = AW'(mc1);
      ifc.divi_row_idx    = JW'(dr);
      ifc.divi_col_idx1   = AW'(dc1);
      ifc.multi_row_idx2  = JW'(mr2);
      ifc.mutli_col_idx2  = AW'(mc2);
      ifc.divi_row_idx2   = JW'(dr2);
      ifc.divi_col_idx2   = AW'(dc2);
      ifc.index_in_tvalid = 1'b1;
      ok = m_run && (st == 2'b01 || st == 2'b10) && rng(mr, mc1) && rng(dr, dc1) &&
           (st == 2'b01 || (rng(mr2, mc2) && rng(dr2, dc2)));
      if (!ok) begin
         m_err = 1'b1;
      end else begin
         cand = m_base + m_tbl[mr][mc1] - m_tbl[dr][dc1];
         if (st == 2'b10) cand += m_tbl[mr2][mc2] - m_tbl[dr2][dc2];
         m_cnt++;
         if (cand > m_best) begin
            m_best = cand; m_row = mr; m_col1 = mc1; m_pair = (st == 2'b10);
            m_row2 = m_pair ? mr2 : J;
            m_col2 = m_pair ? mc2 : 0;
         end
      end
      cyc();
   endtask

   task automatic end_run();
      exp_t e;
      int   lat;
      bit   found;
      idle();
      ifc.state_in = 2'b11;
      sb.push_back('{base: m_base, best: m_best, row: m_row, row2: m_row2, col1: m_col1,
                     col2: m_col2, cnt: m_cnt, pair: m_pair, err: m_err});
      m_run = 1'b0;
      cyc();
      ifc.state_in = 2'b00;
      lat   = 1;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (result_tvalid) found = 1'b1;
         else begin
            cyc();
            lat++;
         end
      end
      chk("result_seen", found, 1);
      chk("result_latency", lat, 3);
      e = sb.pop_front();
      chk("base_metric", base_metric, e.base);
      chk("best_metric", best_metric, e.best);
      chk("best_row_idx", best_row_idx, e.row);
      chk("best_row_idx2", best_row_idx2, e.row2);
      chk("best_col_idx1", best_col_idx1, e.col1);
      chk("best_col_idx2", best_col_idx2, e.col2);
      chk("best_is_pair", best_is_pair, e.pair);
      chk("cand_count", cand_count, e.cnt);
      chk("err", err, e.err);
      cyc();
      chk("result_pulse_one_cycle", result_tvalid, 0);
   endtask

   initial begin
      idle();
      ifc.multi_row_idx = '0; ifc.multi_row_idx2 = '0; ifc.divi_row_idx = '0; ifc.divi_row_idx2 = '0;
      ifc.mutli_col_idx1 = '0; ifc.mutli_col_idx2 = '0; ifc.divi_col_idx1 = '0; ifc.divi_col_idx2 = '0;
      for (int j = 0; j < J; j++) for (int k = 0; k < A; k++) m_tbl[j][k] = 0;
      m_run = 0;
      repeat (3) cyc();
      chk("base_metric", base_metric, 0);
      chk("best_metric", best_metric, 0);
      chk("best_row_idx", best_row_idx, J);
      chk("best_row_idx2", best_row_idx2, J);
      chk("best_col_idx1", best_col_idx1, 0);
      chk("best_col_idx2", best_col_idx2, 0);
      chk("best_is_pair", best_is_pair, 0);
      chk("cand_count", cand_count, 0);
      chk("result_tvalid", result_tvalid, 0);
      chk("err", err, 0);
      chk("idx_ready", ifc.idx_ready, 0);
      rst_n = 1'b1;
      cyc();

      cur_test = "single_stream";
      for (int j = 0; j < J; j++) begin
         wr(j, 0, 0);
         wr(j, 1, j);
      end
      start('0, 1'b0);
      for (int r = 0; r < J; r++) beat(2'b01, r, 1, r, 0);
      end_run();
      chk("lit_best_metric", best_metric, 13);
      chk("lit_best_row", best_row_idx, 13);
      chk("lit_cand_count", cand_count, 14);

      cur_test = "pair_beat";
      start('0, 1'b0);
      beat(2'b10, 12, 1, 12, 0, 13, 1, 13, 0);
      idle();
      chk("pair_not_before_t2", best_is_pair, 0);
      cyc();
      chk("pair_at_t2", best_is_pair, 1);
      chk("count_at_t2", cand_count, 1);
      end_run();
      chk("lit_best_metric", best_metric, 25);
      chk("lit_best_row2", best_row_idx2, 13);

      cur_test = "dropped_beats";
      start(14'h0006, 1'b1);
      chk("err_after_base_beat", err, 1);
      beat(2'b01, 14, 1, 0, 0);
      beat(2'b01, 5, 1, 5, 0);
      idle();
      cyc();
      end_run();
      chk("lit_best_metric", best_metric, 8);
      chk("lit_cand_count", cand_count, 1);

      cur_test = "all_equal";
      for (int j = 0; j < J; j++) begin
         wr(j, 0, 5);
         wr(j, 1, 5);
      end
      start('0, 1'b0);
      beat(2'b01, 0, 1, 0, 0);
      beat(2'b01, 7, 0, 3, 1);
      beat(2'b10, 1, 1, 2, 0, 2, 1, 1, 0);
      beat(2'b01, 13, 1, 13, 0);
      end_run();
      chk("lit_best_metric", best_metric, 70);
      chk("lit_best_row", best_row_idx, 14);

      cur_test = "negative_entries";
      wr(3, 1, -32768);
      wr(3, 0, 32767);
      start('0, 1'b0);
      beat(2'b01, 3, 1, 3, 0);
      idle();
      cyc();
      chk("no_update_low_cand", best_metric, 32832);
      beat(2'b01, 3, 0, 3, 1);
      end_run();
      chk("lit_best_metric", best_metric, 98367);

      cur_test = "reset_mid_run";
      start('0, 1'b0);
      beat(2'b01, 4, 1, 4, 0);
      idle();
      #2 rst_n = 1'b0;
      #1;
      chk("idx_ready", ifc.idx_ready, 0);
      chk("base_metric", base_metric, 0);
      chk("best_metric", best_metric, 0);
      chk("best_row_idx", best_row_idx, J);
      chk("cand_count", cand_count, 0);
      for (int j = 0; j < J; j++) for (int k = 0; k < A; k++) m_tbl[j][k] = 0;
      m_run = 0;
      cyc();
      rst_n = 1'b1;
      cyc();
      start(14'h3FFF, 1'b0);
      beat(2'b01, 2, 1, 2, 0);
      end_run();
      chk("lit_base_after_reset", base_metric, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
